// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared definitions for the ALU issue controller: slow-op
//               select codes, the slow-op classifier and the sequencer
//               state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    // Select codes that need extra settling time in the combinational ALU
    localparam logic [3:0] SEL_MUL  = 4'b1001;
    localparam logic [3:0] SEL_DIV1 = 4'b1011;
    localparam logic [3:0] SEL_DIV2 = 4'b1101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic is_muldiv(input logic [3:0] sel);
        return (sel == SEL_MUL) || (sel == SEL_DIV1) || (sel == SEL_DIV2);
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_issue_ctrl_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb2
// Description : Combinational two-way round-robin grant.
//               valid[1:0]  in  : request lines
//               last_grant  in  : index of the most recent winner
//               grant[1:0]  out : one-hot grant (or zero when idle)
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2 (
    input  logic [1:0] valid,
    input  logic       last_grant,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        if (valid == 2'b11) begin
            // Both asking: the one that did not win last time goes first
            grant = last_grant ? 2'b01 : 2'b10;
        end else begin
            grant = valid;
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : alu_issue_ctrl
// Description : Two-requester sequencer in front of a shared combinational
//               ALU. Accepts one operation at a time, registers operands into
//               the ALU, waits 1 or MD_LAT cycles, then presents the captured
//               result and flags on a valid/ready response channel.
// Ports       : clk, rst                      clock, async active-high reset
//               req{0,1}_valid/ready/sel/a/b  request handshakes + payload
//               alu_a/alu_b/alu_sel           registered operands to ALU
//               alu_dout/alu_v/alu_c          ALU result and flags
//               rsp_valid/ready/id/data       response handshake + payload
//               rsp_v/rsp_c/rsp_z             captured flags
//               busy                          high whenever not IDLE
// Revision    : 1.0 - initial release
// ============================================================================
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int BW     = 8,
    parameter int MD_LAT = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic [3:0]    req0_sel,
    input  logic [BW-1:0] req0_a,
    input  logic [BW-1:0] req0_b,
    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic [3:0]    req1_sel,
    input  logic [BW-1:0] req1_a,
    input  logic [BW-1:0] req1_b,
    output logic [BW-1:0] alu_a,
    output logic [BW-1:0] alu_b,
    output logic [3:0]    alu_sel,
    input  logic [BW-1:0] alu_dout,
    input  logic          alu_v,
    input  logic          alu_c,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic          rsp_id,
    output logic [BW-1:0] rsp_data,
    output logic          rsp_v,
    output logic          rsp_c,
    output logic          rsp_z,
    output logic          busy
);

    // A latency below one cycle is meaningless; clamp it
    localparam int c_lat_eff = (MD_LAT < 1) ? 1 : MD_LAT;
    localparam int c_cw      = $clog2(c_lat_eff + 1);
    localparam logic [c_cw-1:0] c_lat_md  = c_cw'(c_lat_eff);
    localparam logic [c_cw-1:0] c_lat_one = c_cw'(1);

    state_t          r_state;
    logic [c_cw-1:0] r_cnt;
    logic            r_last;
    logic [BW-1:0]   r_alu_a;
    logic [BW-1:0]   r_alu_b;
    logic [3:0]      r_alu_sel;
    logic            r_rsp_valid;
    logic            r_rsp_id;
    logic [BW-1:0]   r_rsp_data;
    logic            r_rsp_v;
    logic            r_rsp_c;
    logic            r_rsp_z;

    logic [1:0]      w_grant;
    logic [1:0]      w_take;
    logic [3:0]      w_sel;
    logic [BW-1:0]   w_a;
    logic [BW-1:0]   w_b;

    rr_arb2 u_arb (
        .valid      ({req1_valid, req0_valid}),
        .last_grant (r_last),
        .grant      (w_grant)
    );

    // Grants only take effect while idle
    assign w_take     = (r_state == IDLE) ? w_grant : 2'b00;
    assign req0_ready = w_take[0];
    assign req1_ready = w_take[1];

    assign w_sel = w_take[1] ? req1_sel : req0_sel;
    assign w_a   = w_take[1] ? req1_a   : req0_a;
    assign w_b   = w_take[1] ? req1_b   : req0_b;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_last      <= 1'b1;
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_alu_sel   <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_v     <= 1'b0;
            r_rsp_c     <= 1'b0;
            r_rsp_z     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (|w_take) begin
                        r_alu_sel <= w_sel;
                        r_alu_a   <= w_a;
                        r_alu_b   <= w_b;
                        r_rsp_id  <= w_take[1];
                        r_last    <= w_take[1];
                        r_cnt     <= is_muldiv(w_sel) ? c_lat_md : c_lat_one;
                        r_state   <= EXEC;
                    end
                end
                EXEC: begin
                    r_cnt <= r_cnt - c_lat_one;
                    if (r_cnt == c_lat_one) begin
                        r_rsp_data  <= alu_dout;
                        r_rsp_z     <= (alu_dout == '0);
                        // Logic/mul/div codes produce no meaningful V/C
                        r_rsp_v     <= r_alu_sel[3] ? 1'b0 : alu_v;
                        r_rsp_c     <= r_alu_sel[3] ? 1'b0 : alu_c;
                        r_rsp_valid <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign alu_a     = r_alu_a;
    assign alu_b     = r_alu_b;
    assign alu_sel   = r_alu_sel;
    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_data  = r_rsp_data;
    assign rsp_v     = r_rsp_v;
    assign rsp_c     = r_rsp_c;
    assign rsp_z     = r_rsp_z;
    assign busy      = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_issue_ctrl
// Description : Self-checking bench for alu_issue_ctrl with a behavioural
//               ALU, a timeline reference model, directed scenarios and a
//               randomized phase.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_issue_ctrl;

    localparam int BW     = 8;
    localparam int MD_LAT = 4;
    localparam int LAT    = (MD_LAT < 1) ? 1 : MD_LAT;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req0_valid = 1'b0, req1_valid = 1'b0;
    logic          req0_ready, req1_ready;
    logic [3:0]    req0_sel = '0, req1_sel = '0;
    logic [BW-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [BW-1:0] alu_a, alu_b, alu_dout;
    logic [3:0]    alu_sel;
    logic          alu_v, alu_c;
    logic          rsp_valid, rsp_id, rsp_v, rsp_c, rsp_z, busy;
    logic          rsp_ready = 1'b0;
    logic [BW-1:0] rsp_data;

    always #5 clk = ~clk;

    alu_issue_ctrl #(.BW(BW), .MD_LAT(MD_LAT)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_sel(req0_sel),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_sel(req1_sel),
        .req1_a(req1_a), .req1_b(req1_b),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .alu_dout(alu_dout), .alu_v(alu_v), .alu_c(alu_c),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_v(rsp_v), .rsp_c(rsp_c), .rsp_z(rsp_z),
        .busy(busy)
    );

    // Behavioural ALU: returns {v, c, dout}. Logic/mul/div codes drive junk
    // V/C on purpose so the controller's masking is observable.
    function automatic logic [BW+1:0] balu(input logic [3:0] sel,
                                           input logic [BW-1:0] a,
                                           input logic [BW-1:0] b);
        logic [BW:0]     s;
        logic [2*BW-1:0] p;
        logic [BW-1:0]   d;
        logic            v, c;
        s = '0; p = '0; d = '0; v = 1'b0; c = 1'b0;
        if (!sel[3]) begin
            if (sel[0]) begin
                s = {1'b0, a} - {1'b0, b};
                v = (a[BW-1] != b[BW-1]) && (s[BW-1] != a[BW-1]);
            end else begin
                s = {1'b0, a} + {1'b0, b};
                v = (a[BW-1] == b[BW-1]) && (s[BW-1] != a[BW-1]);
            end
            d = s[BW-1:0];
            c = s[BW];
        end else begin
            v = b[0];
            c = a[0];
            case (sel)
                4'b1000: d = a & b;
                4'b1010: d = a | b;
                4'b1100: d = a ^ b;
                4'b1110: d = ~a;
                4'b1001: begin p = a * b; d = p[BW-1:0]; end
                4'b1011: d = (b == '0) ? '1 : a / b;
                4'b1101: d = (b == '0) ? a : a % b;
                default: d = a;
            endcase
        end
        return {v, c, d};
    endfunction

    assign {alu_v, alu_c, alu_dout} = balu(alu_sel, alu_a, alu_b);

    function automatic int op_lat(input logic [3:0] sel);
        return (sel == 4'b1001 || sel == 4'b1011 || sel == 4'b1101) ? LAT : 1;
    endfunction

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Requester intents (held until the model sees them accepted)
    logic          d_v [2];
    logic [3:0]    d_sel [2];
    logic [BW-1:0] d_a [2];
    logic [BW-1:0] d_b [2];
    logic          d_rr;

    // Reference model: an op is outstanding for op_lat cycles after accept,
    // then its response is shown until consumed; new grants only when free.
    bit            m_busy, m_rv;
    int            m_left;
    logic          m_last;
    logic [3:0]    m_sel;
    logic [BW-1:0] m_a, m_b;
    logic          e_id, e_v, e_c, e_z;
    logic [BW-1:0] e_data;

    bit   lastacc;
    int   lastacc_id;
    logic s_r0, s_r1;

    logic [3:0] sel_tab [8] = '{4'b0000, 4'b0001, 4'b1000, 4'b1010,
                                4'b1100, 4'b1001, 4'b1011, 4'b1101};

    task automatic model_reset();
        m_busy = 0; m_rv = 0; m_left = 0; m_last = 1'b1;
        m_sel = '0; m_a = '0; m_b = '0;
        e_id = 0; e_v = 0; e_c = 0; e_z = 0; e_data = '0;
    endtask

    function automatic int model_grant();
        if (m_busy || m_rv) return -1;
        if (d_v[0] && d_v[1]) return m_last ? 0 : 1;
        if (d_v[0]) return 0;
        if (d_v[1]) return 1;
        return -1;
    endfunction

    task automatic set_req(input int n, input logic [3:0] sel,
                           input logic [BW-1:0] a, input logic [BW-1:0] b);
        d_v[n] = 1'b1; d_sel[n] = sel; d_a[n] = a; d_b[n] = b;
    endtask

    // One clock: drive, compare against model, advance model at the edge
    task automatic step();
        int g;
        logic [BW+1:0] r;
        @(negedge clk);
        req0_valid = d_v[0]; req0_sel = d_sel[0]; req0_a = d_a[0]; req0_b = d_b[0];
        req1_valid = d_v[1]; req1_sel = d_sel[1]; req1_a = d_a[1]; req1_b = d_b[1];
        rsp_ready  = d_rr;
        #1;
        g = model_grant();
        s_r0 = req0_ready; s_r1 = req1_ready;
        chk("req0_ready", 32'(req0_ready), 32'(g == 0));
        chk("req1_ready", 32'(req1_ready), 32'(g == 1));
        chk("busy",       32'(busy),       32'(m_busy || m_rv));
        chk("rsp_valid",  32'(rsp_valid),  32'(m_rv));
        chk("rsp_id",     32'(rsp_id),     32'(e_id));
        chk("rsp_data",   32'(rsp_data),   32'(e_data));
        chk("rsp_v",      32'(rsp_v),      32'(e_v));
        chk("rsp_c",      32'(rsp_c),      32'(e_c));
        chk("rsp_z",      32'(rsp_z),      32'(e_z));
        chk("alu_a",      32'(alu_a),      32'(m_a));
        chk("alu_b",      32'(alu_b),      32'(m_b));
        chk("alu_sel",    32'(alu_sel),    32'(m_sel));
        @(posedge clk);
        lastacc = 0;
        if (g >= 0) begin
            m_busy = 1; m_left = op_lat(d_sel[g]);
            m_sel = d_sel[g]; m_a = d_a[g]; m_b = d_b[g];
            e_id = (g == 1); m_last = (g == 1);
            lastacc = 1; lastacc_id = g;
            d_v[g] = 1'b0;
        end else if (m_busy) begin
            m_left--;
            if (m_left == 0) begin
                m_busy = 0; m_rv = 1;
                r = balu(m_sel, m_a, m_b);
                e_data = r[BW-1:0];
                e_z    = (e_data == '0);
                e_c    = m_sel[3] ? 1'b0 : r[BW];
                e_v    = m_sel[3] ? 1'b0 : r[BW+1];
            end
        end else if (m_rv && d_rr) begin
            m_rv = 0;
        end
    endtask

    task automatic wait_accept();
        int n;
        n = 0;
        do begin step(); n++; end while (!lastacc && n < 40);
        chk("accept_seen", 32'(lastacc), 32'd1);
    endtask

    task automatic wait_rsp();
        int n;
        n = 0;
        do begin step(); #1; n++; end while (!rsp_valid && n < 40);
        chk("rsp_seen", 32'(rsp_valid), 32'd1);
    endtask

    // Asynchronous reset pulse placed between clock edges
    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_busy",      32'(busy),      32'd0);
        chk("rst_alu_a",     32'(alu_a),     32'd0);
        chk("rst_alu_b",     32'(alu_b),     32'd0);
        chk("rst_alu_sel",   32'(alu_sel),   32'd0);
        chk("rst_rsp_id",    32'(rsp_id),    32'd0);
        model_reset();
        d_v[0] = 1'b0; d_v[1] = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        rst = 1'b0;
    endtask

    initial begin
        d_v[0] = 0; d_v[1] = 0;
        d_sel[0] = '0; d_sel[1] = '0;
        d_a[0] = '0; d_a[1] = '0; d_b[0] = '0; d_b[1] = '0;
        d_rr = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #3;
        do_reset();

        // Single AND from requester 0
        set_req(0, 4'b1000, 8'hF0, 8'h3C);
        step();
        chk("and_ready0", 32'(s_r0), 32'd1);
        chk("and_accept", 32'(lastacc), 32'd1);
        #1;
        chk("and_not_yet", 32'(rsp_valid), 32'd0);
        chk("and_alu_a",   32'(alu_a), 32'hF0);
        step();
        #1;
        chk("and_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("and_data", 32'(rsp_data), 32'h30);
        chk("and_z",    32'(rsp_z), 32'd0);
        chk("and_v",    32'(rsp_v), 32'd0);
        chk("and_c",    32'(rsp_c), 32'd0);
        chk("and_id",   32'(rsp_id), 32'd0);

        // XOR to zero from requester 1
        set_req(1, 4'b1100, 8'h55, 8'h55);
        wait_accept();
        chk("xor_grant", 32'(lastacc_id), 32'd1);
        wait_rsp();
        chk("xor_data", 32'(rsp_data), 32'h00);
        chk("xor_z",    32'(rsp_z), 32'd1);
        chk("xor_id",   32'(rsp_id), 32'd1);

        // MUL latency
        set_req(0, 4'b1001, 8'h0F, 8'h03);
        wait_accept();
        for (int k = 1; k < LAT; k++) begin
            step();
            #1;
            chk("mul_wait_valid", 32'(rsp_valid), 32'd0);
            chk("mul_hold_sel",   32'(alu_sel), 32'h9);
            chk("mul_hold_a",     32'(alu_a), 32'h0F);
            chk("mul_hold_b",     32'(alu_b), 32'h03);
        end
        step();
        #1;
        chk("mul_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("mul_data", 32'(rsp_data), 32'h2D);
        chk("mul_v",    32'(rsp_v), 32'd0);
        chk("mul_c",    32'(rsp_c), 32'd0);

        // Contention after a fresh reset: grants alternate starting at 0
        #2;
        do_reset();
        d_rr = 1'b1;
        set_req(0, sel_tab[$urandom % 8], 8'($urandom), 8'($urandom));
        set_req(1, sel_tab[$urandom % 8], 8'($urandom), 8'($urandom));
        for (int k = 0; k < 4; k++) begin
            wait_accept();
            chk("contend_grant", 32'(lastacc_id), 32'(k % 2));
            if (k < 3) set_req(lastacc_id, sel_tab[$urandom % 8], 8'($urandom), 8'($urandom));
        end
        wait_accept();
        chk("contend_tail", 32'(lastacc_id), 32'd0);

        // Backpressure in DONE
        set_req(0, 4'b0000, 8'h7F, 8'h01);
        wait_accept();
        d_rr = 1'b0;
        wait_rsp();
        set_req(1, 4'b1010, 8'h0F, 8'hF0);
        for (int k = 0; k < 5; k++) begin
            step();
            #1;
            chk("bp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_data",  32'(rsp_data), 32'h80);
            chk("bp_v",     32'(rsp_v), 32'd1);
            chk("bp_busy",  32'(busy), 32'd1);
            chk("bp_ready1", 32'(req1_ready), 32'd0);
        end
        d_rr = 1'b1;
        step();
        #1;
        chk("bp_release_busy",  32'(busy), 32'd0);
        chk("bp_release_valid", 32'(rsp_valid), 32'd0);
        wait_accept();
        chk("bp_next_grant", 32'(lastacc_id), 32'd1);

        // Reset in the middle of a MUL
        set_req(0, 4'b1001, 8'h11, 8'h02);
        wait_accept();
        step();
        #2;
        do_reset();
        repeat (LAT + 2) step();
        #1;
        chk("drop_no_rsp", 32'(rsp_valid), 32'd0);
        set_req(1, 4'b0001, 8'h10, 8'h20);
        wait_accept();
        chk("post_rst_grant", 32'(lastacc_id), 32'd1);
        wait_rsp();
        chk("post_rst_data", 32'(rsp_data), 32'hF0);
        chk("post_rst_c",    32'(rsp_c), 32'd1);
        chk("post_rst_v",    32'(rsp_v), 32'd0);
        chk("post_rst_id",   32'(rsp_id), 32'd1);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            for (int n = 0; n < 2; n++) begin
                if (!d_v[n] && ($urandom % 3 == 0))
                    set_req(n, sel_tab[$urandom % 8], 8'($urandom), 8'($urandom));
            end
            d_rr = (($urandom % 4) != 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
